// File: rtl/uart_core_param_if.sv
// ---------------------------------------------------------------------------
// uart_core_param_if
// Byte-stream side of the parametrised UART core.
//
// Signals:
//   tx_data       word to transmit (client -> core)
//   tx_valid      tx_data valid (client -> core)
//   tx_ready      transmitter can accept a word (core -> client)
//   rx_data       last received word (core -> client)
//   rx_valid      one-cycle pulse when a frame completes (core -> client)
//   rx_parity_err parity mismatch, qualified by rx_valid (core -> client)
//   rx_frame_err  first stop bit sampled low, qualified by rx_valid
//
// Modports:
//   master  client side (FIFO or register bank)
//   slave   UART core side
// ---------------------------------------------------------------------------
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_core_param.sv
// ---------------------------------------------------------------------------
// uart_core_param
// Parametrised full-duplex UART core: configurable data width, parity and
// stop bits, valid/ready transmit handshake, 16x-style oversampled receiver
// with 3-sample majority vote, false-start rejection and per-frame
// parity/framing error flags.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    byte-stream client interface (slave modport)
//   tx     serial output, idles high
//   rx     serial input, asynchronous to clk
// ---------------------------------------------------------------------------
module uart_core_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_core_param_if.slave  bus,
    output logic              tx,
    input  logic              rx
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = $clog2(DIV + 1);
    localparam int TICK_W  = $clog2(STOP_BITS * OVERSAMPLE + 1);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SAMP_A    = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] SAMP_B    = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] SAMP_C    = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

    // -----------------------------------------------------------------------
    // Shared tick generator. With DIV=1 the compare is always true, so tick
    // is high every clock.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] divCnt_q;
    logic             tick;

    assign tick = (divCnt_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q <= '0;
        end else if (tick) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } txState_t;

    txState_t             txState_q;
    logic [DATA_BITS-1:0] txShift_q;
    logic                 txPar_q;
    logic [BIT_W-1:0]     txBit_q;
    logic [TICK_W-1:0]    txTick_q;
    logic                 txReady_q;
    logic                 tx_q;

    // The line level is registered and updated on the same edge as the state
    // change, so each bit is held for exactly one bit period of ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txState_q <= TX_IDLE;
            txShift_q <= '0;
            txPar_q   <= 1'b0;
            txBit_q   <= '0;
            txTick_q  <= '0;
            txReady_q <= 1'b1;
            tx_q      <= 1'b1;
        end else begin
            case (txState_q)
                TX_IDLE: begin
                    tx_q      <= 1'b1;
                    txReady_q <= 1'b1;
                    if (bus.tx_valid && txReady_q) begin
                        txShift_q <= bus.tx_data;
                        txPar_q   <= (PARITY == 1) ? ~(^bus.tx_data) : ^bus.tx_data;
                        txReady_q <= 1'b0;
                        tx_q      <= 1'b0;
                        txTick_q  <= '0;
                        txState_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (txTick_q == BIT_LAST) begin
                            txTick_q  <= '0;
                            txBit_q   <= '0;
                            tx_q      <= txShift_q[0];
                            txState_q <= TX_DATA;
                        end else begin
                            txTick_q <= txTick_q + 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (txTick_q == BIT_LAST) begin
                            txTick_q <= '0;
                            if (txBit_q == DATA_LAST) begin
                                if (PARITY != 0) begin
                                    tx_q      <= txPar_q;
                                    txState_q <= TX_PARITY;
                                end else begin
                                    tx_q      <= 1'b1;
                                    txState_q <= TX_STOP;
                                end
                            end else begin
                                // Bit 1 of the current word becomes the next line level.
                                txBit_q   <= txBit_q + 1'b1;
                                tx_q      <= txShift_q[1];
                                txShift_q <= txShift_q >> 1;
                            end
                        end else begin
                            txTick_q <= txTick_q + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        if (txTick_q == BIT_LAST) begin
                            txTick_q  <= '0;
                            tx_q      <= 1'b1;
                            txState_q <= TX_STOP;
                        end else begin
                            txTick_q <= txTick_q + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (txTick_q == STOP_LAST) begin
                            txTick_q  <= '0;
                            txReady_q <= 1'b1;
                            txState_q <= TX_IDLE;
                        end else begin
                            txTick_q <= txTick_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q      <= 1'b1;
                    txReady_q <= 1'b1;
                    txState_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign bus.tx_ready = txReady_q;

    // -----------------------------------------------------------------------
    // Receiver input synchroniser; rxPrev_q gives the falling-edge detect.
    // -----------------------------------------------------------------------
    logic rxSync1_q, rxSync2_q, rxPrev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxPrev_q  <= 1'b1;
        end else begin
            rxSync1_q <= rx;
            rxSync2_q <= rxSync1_q;
            rxPrev_q  <= rxSync2_q;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rxState_t;

    rxState_t             rxState_q;
    logic [TICK_W-1:0]    rxTick_q;
    logic                 rxS0_q, rxS1_q;
    logic [BIT_W-1:0]     rxBit_q;
    logic [DATA_BITS-1:0] rxShift_q;
    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxParBit_q;
    logic                 rxValid_q;
    logic                 rxParErr_q;
    logic                 rxFrameErr_q;

    logic rxMaj_d;
    logic rxParExp_d;
    logic rxDecide;
    logic rxBitEnd;

    // The third sample is the live synchronised level on the decision tick.
    assign rxMaj_d    = (rxS0_q & rxS1_q) | (rxS0_q & rxSync2_q) | (rxS1_q & rxSync2_q);
    assign rxParExp_d = (PARITY == 1) ? ~(^rxShift_q) : ^rxShift_q;
    assign rxDecide   = tick && (rxTick_q == SAMP_C);
    assign rxBitEnd   = tick && (rxTick_q == BIT_LAST);

    // Stop-bit decision happens mid-bit, so the FSM returns to IDLE half a
    // bit early and is ready for a new start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxState_q    <= RX_IDLE;
            rxTick_q     <= '0;
            rxS0_q       <= 1'b1;
            rxS1_q       <= 1'b1;
            rxBit_q      <= '0;
            rxShift_q    <= '0;
            rxData_q     <= '0;
            rxParBit_q   <= 1'b0;
            rxValid_q    <= 1'b0;
            rxParErr_q   <= 1'b0;
            rxFrameErr_q <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            if (tick && (rxTick_q == SAMP_A)) begin
                rxS0_q <= rxSync2_q;
            end
            if (tick && (rxTick_q == SAMP_B)) begin
                rxS1_q <= rxSync2_q;
            end
            if (tick && (rxState_q != RX_IDLE) && (rxState_q != RX_BREAK)) begin
                rxTick_q <= rxBitEnd ? '0 : rxTick_q + 1'b1;
            end

            case (rxState_q)
                RX_IDLE: begin
                    if (rxPrev_q && !rxSync2_q) begin
                        rxTick_q  <= '0;
                        rxState_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxDecide && rxMaj_d) begin
                        rxState_q <= RX_IDLE;
                    end else if (rxBitEnd) begin
                        rxBit_q   <= '0;
                        rxState_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rxDecide) begin
                        rxShift_q <= {rxMaj_d, rxShift_q[DATA_BITS-1:1]};
                    end
                    if (rxBitEnd) begin
                        if (rxBit_q == DATA_LAST) begin
                            rxState_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rxDecide) begin
                        rxParBit_q <= rxMaj_d;
                    end
                    if (rxBitEnd) begin
                        rxState_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rxDecide) begin
                        rxData_q     <= rxShift_q;
                        rxParErr_q   <= (PARITY != 0) && (rxParBit_q != rxParExp_d);
                        rxFrameErr_q <= ~rxMaj_d;
                        rxValid_q    <= 1'b1;
                        rxState_q    <= rxMaj_d ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (rxSync2_q) begin
                        rxState_q <= RX_IDLE;
                    end
                end
                default: begin
                    rxState_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data       = rxData_q;
    assign bus.rx_valid      = rxValid_q;
    assign bus.rx_parity_err = rxParErr_q;
    assign bus.rx_frame_err  = rxFrameErr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// ---------------------------------------------------------------------------
// tb_uart_core_param
// Directed bench for uart_core_param with three instances sharing one clock:
//   dutA  8N1, rx selectable between loopback and a bench-driven line
//   dutB  8E1, rx selectable between loopback and a bench-driven line
//   dutC  5N2, loopback
// CLK_FREQ=1.6 MHz, BAUD=100k, OVERSAMPLE=16 gives 16 clk per bit.
// ---------------------------------------------------------------------------
module tb_uart_core_param;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   // 10 ns period clock
   always #5 clk = ~clk;

   uart_core_param_if #(.DATA_BITS(8)) ifA ();
   uart_core_param_if #(.DATA_BITS(8)) ifB ();
   uart_core_param_if #(.DATA_BITS(5)) ifC ();

   logic txA, txB, txC;
   logic rxA, rxB, rxC;
   logic selA   = 1'b1;
   logic selB   = 1'b1;
   logic rxDrvA = 1'b1;
   logic rxDrvB = 1'b1;

   assign rxA = selA ? txA : rxDrvA;
   assign rxB = selB ? txB : rxDrvB;
   assign rxC = txC;

   uart_core_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16))
      dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave), .tx(txA), .rx(rxA));

   uart_core_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                     .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16))
      dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave), .tx(txB), .rx(rxB));

   uart_core_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(5),
                     .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16))
      dutC (.clk(clk), .rst_n(rst_n), .bus(ifC.slave), .tx(txC), .rx(rxC));

   int total = 0;
   int bad   = 0;

   // Receive monitors: count rx_valid pulses and capture qualified outputs
   int         cntA = 0, cntB = 0, cntC = 0;
   logic [7:0] lastA = '0, lastB = '0;
   logic [4:0] lastC = '0, prevC = '0;
   logic       perrA = 1'b0, ferrA = 1'b0, perrB = 1'b0, ferrB = 1'b0;

   always @(negedge clk) begin
      if (ifA.rx_valid) begin
         cntA  = cntA + 1;
         lastA = ifA.rx_data;
         perrA = ifA.rx_parity_err;
         ferrA = ifA.rx_frame_err;
      end
      if (ifB.rx_valid) begin
         cntB  = cntB + 1;
         lastB = ifB.rx_data;
         perrB = ifB.rx_parity_err;
         ferrB = ifB.rx_frame_err;
      end
      if (ifC.rx_valid) begin
         cntC  = cntC + 1;
         prevC = lastC;
         lastC = ifC.rx_data;
      end
   end

   // Line monitor mux: selects which transmitter gets recorded
   logic [1:0] mon = 2'd0;
   logic       txMon, rdyMon;

   always_comb begin
      txMon  = txA;
      rdyMon = ifA.tx_ready;
      case (mon)
         2'd1:    begin txMon = txB; rdyMon = ifB.tx_ready; end
         2'd2:    begin txMon = txC; rdyMon = ifC.tx_ready; end
         default: begin txMon = txA; rdyMon = ifA.tx_ready; end
      endcase
   end

   logic smpTx  [512];
   logic smpRdy [512];

   // Compare one observation and report on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one word on a transmit handshake for one clock
   task automatic applyStimulus(input int which, input logic [7:0] d);
      @(negedge clk);
      if (which == 0) begin ifA.tx_data = d; ifA.tx_valid = 1'b1; end
      else            begin ifB.tx_data = d; ifB.tx_valid = 1'b1; end
      @(negedge clk);
      ifA.tx_valid = 1'b0;
      ifB.tx_valid = 1'b0;
   endtask

   // Record the monitored line for n clocks; optionally drop C's tx_valid
   task automatic captureLine(input int n, input int dropAt);
      for (int i = 0; i < n; i++) begin
         smpTx[i]  = txMon;
         smpRdy[i] = rdyMon;
         if (i == dropAt) ifC.tx_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   // Drive a bit vector (LSB first, 16 clk per bit) onto A or B rx line
   task automatic driveSerial(input int which, input logic [15:0] bits, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         if (which == 0) rxDrvA = bits[k]; else rxDrvB = bits[k];
         repeat (16) @(negedge clk);
      end
      if (which == 0) rxDrvA = 1'b1; else rxDrvB = 1'b1;
   endtask

   // Mid-bit line levels of a recorded frame starting at sample base
   function automatic logic [15:0] bitsAt(input int base, input int nbits);
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < nbits; k++) v[k] = smpTx[base + 16*k + 8];
      return v;
   endfunction

   // Number of samples in a frame that differ from the first sample of their bit
   function automatic int unstable(input int base, input int nbits);
      int u;
      u = 0;
      for (int k = 0; k < nbits; k++)
         for (int j = 0; j < 16; j++)
            if (smpTx[base + 16*k + j] !== smpTx[base + 16*k]) u++;
      return u;
   endfunction

   function automatic int lowCount(input int n);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) if (smpRdy[i] === 1'b0) c++;
      return c;
   endfunction

   int base;

   initial begin
      ifA.tx_data = '0; ifA.tx_valid = 1'b0;
      ifB.tx_data = '0; ifB.tx_valid = 1'b0;
      ifC.tx_data = '0; ifC.tx_valid = 1'b0;

      // Reset values
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_tx",       txA, 1);
      checkOutput("rst_tx_ready", ifA.tx_ready, 1);
      checkOutput("rst_rx_data",  ifA.rx_data, 0);
      checkOutput("rst_rx_valid", ifA.rx_valid, 0);
      checkOutput("rst_perr",     ifA.rx_parity_err, 0);
      checkOutput("rst_ferr",     ifA.rx_frame_err, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1 loopback of 0xA5
      base = cntA;
      mon  = 2'd0;
      applyStimulus(0, 8'hA5);
      captureLine(200, -1);
      checkOutput("a5_pattern",   bitsAt(0, 10), 16'({1'b1, 8'hA5, 1'b0}));
      checkOutput("a5_stable",    unstable(0, 10), 0);
      checkOutput("a5_ready_low", lowCount(200), 160);
      checkOutput("a5_count",     cntA - base, 1);
      checkOutput("a5_data",      lastA, 8'hA5);
      checkOutput("a5_perr",      perrA, 0);
      checkOutput("a5_ferr",      ferrA, 0);

      // Glitch of 4 clk: false start rejected, receiver ready again 9 clk later
      selA = 1'b0;
      base = cntA;
      rxDrvA = 1'b0;
      repeat (4) @(negedge clk);
      rxDrvA = 1'b1;
      repeat (9) @(negedge clk);
      checkOutput("glitch_no_valid", cntA - base, 0);
      driveSerial(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
      repeat (8) @(negedge clk);
      checkOutput("glitch_next_count", cntA - base, 1);
      checkOutput("glitch_next_data",  lastA, 8'h5A);

      // Framing error: 0x3C with stop held low for 3 bit periods
      base = cntA;
      driveSerial(0, 16'({3'b000, 8'h3C, 1'b0}), 12);
      repeat (10) @(negedge clk);
      checkOutput("ferr_count", cntA - base, 1);
      checkOutput("ferr_flag",  ferrA, 1);
      checkOutput("ferr_data",  lastA, 8'h3C);
      checkOutput("ferr_perr",  perrA, 0);
      repeat (64) @(negedge clk);
      checkOutput("ferr_no_second", cntA - base, 1);
      checkOutput("ferr_held",      ifA.rx_frame_err, 1);
      driveSerial(0, 16'({1'b1, 8'h81, 1'b0}), 10);
      repeat (8) @(negedge clk);
      checkOutput("ferr_clear_count", cntA - base, 2);
      checkOutput("ferr_clear_flag",  ferrA, 0);
      checkOutput("ferr_clear_data",  lastA, 8'h81);
      selA = 1'b1;

      // 8E1 loopback of 0x07: parity bit 1, 11-bit frame
      base = cntB;
      mon  = 2'd1;
      applyStimulus(1, 8'h07);
      captureLine(200, -1);
      checkOutput("e1_pattern",    bitsAt(0, 11), 16'({1'b1, 1'b1, 8'h07, 1'b0}));
      checkOutput("e1_parity_bit", smpTx[9*16 + 8], 1);
      checkOutput("e1_stable",     unstable(0, 11), 0);
      checkOutput("e1_ready_low",  lowCount(200), 176);
      checkOutput("e1_count",      cntB - base, 1);
      checkOutput("e1_data",       lastB, 8'h07);
      checkOutput("e1_perr",       perrB, 0);

      // 8E1 frame with parity bit forced to 0
      selB = 1'b0;
      base = cntB;
      driveSerial(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
      repeat (8) @(negedge clk);
      checkOutput("e1bad_count", cntB - base, 1);
      checkOutput("e1bad_perr",  perrB, 1);
      checkOutput("e1bad_data",  lastB, 8'h07);
      checkOutput("e1bad_ferr",  ferrB, 0);
      selB = 1'b1;

      // 5N2 back-to-back: 0x1F then 0x00 with tx_valid held high
      base = cntC;
      mon  = 2'd2;
      @(negedge clk);
      ifC.tx_data  = 5'h1F;
      ifC.tx_valid = 1'b1;
      @(negedge clk);
      ifC.tx_data  = 5'h00;
      captureLine(300, 129);
      checkOutput("c_f1_pattern",   bitsAt(0, 8), 16'({2'b11, 5'h1F, 1'b0}));
      checkOutput("c_f1_stable",    unstable(0, 8), 0);
      checkOutput("c_f1_ready_low", lowCount(128), 128);
      checkOutput("c_gap_idle",     smpTx[128], 1);
      checkOutput("c_gap_ready",    smpRdy[128], 1);
      checkOutput("c_f2_start",     smpTx[129], 0);
      checkOutput("c_f2_pattern",   bitsAt(129, 8), 16'({2'b11, 5'h00, 1'b0}));
      checkOutput("c_rx_count",     cntC - base, 2);
      checkOutput("c_rx_first",     prevC, 5'h1F);
      checkOutput("c_rx_second",    lastC, 5'h00);

      // Reset asserted mid-DATA of A's transmitter and receiver
      base = cntA;
      mon  = 2'd0;
      applyStimulus(0, 8'hC3);
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_tx",       txA, 1);
      checkOutput("mid_rst_tx_ready", ifA.tx_ready, 1);
      checkOutput("mid_rst_rx_valid", ifA.rx_valid, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("mid_rst_no_valid", cntA - base, 0);
      applyStimulus(0, 8'h96);
      captureLine(200, -1);
      checkOutput("post_rst_pattern", bitsAt(0, 10), 16'({1'b1, 8'h96, 1'b0}));
      checkOutput("post_rst_count",   cntA - base, 1);
      checkOutput("post_rst_data",    lastA, 8'h96);
      checkOutput("post_rst_ferr",    ferrA, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART core; successor to the fixed 8N1 transmitter/receiver.
- Adds configurable data width, parity and stop bits, plus a 16x-oversampled receiver with majority-vote sampling and false-start rejection.
- Adds valid/ready transmit handshake and per-frame parity/framing error flags.
- Sits between the serial pins and a byte-stream client (FIFO or register bank).

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter can accept a word.
- tx  out  1  serial output; idles high.
- rx  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid.
- rx_frame_err  out  1  first stop bit sampled 0; qualified by rx_valid.

Behaviour:
- One clock. Reset is asynchronous, active-low (rst_n); all state clears immediately on assertion.
- Reset values: tx=1, tx_ready=1, rx_data=0, rx_valid=0, both error flags 0, both FSMs IDLE, rx synchroniser flops=1.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, minimum 1. A free-running counter pulses tick for one clk every DIV cycles. One tick generator is shared by TX and RX.
- Bit period = OVERSAMPLE ticks. Frame order: start(0), data LSB first, optional parity, stop bit(s) high.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1. On tx_valid&&tx_ready, latch tx_data, compute parity, drop tx_ready. Enter START on the next clk, with tx=0 on that same cycle.
  - Each state holds tx for exactly OVERSAMPLE ticks, counted by a tick counter that is reset at entry.
  - Parity bit: even mode = XOR of data bits; odd mode = its inverse. PARITY=0 skips the PARITY state.
  - STOP lasts STOP_BITS bit periods, then returns to IDLE and raises tx_ready.
  - tx_valid while busy is ignored; data is not captured. Back-to-back frames may therefore be separated by one idle clk.
- RX path: 2-flop synchroniser on rx; all logic uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge of synced rx resets the tick counter and enters START.
  - Every bit is resolved by majority of three samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of its bit period.
  - START: if the majority is 1, it is a false start; return to IDLE with no rx_valid.
  - DATA: shift in DATA_BITS bits, LSB first.
  - PARITY (when enabled): compare the received parity bit against parity computed by the PARITY-mode rule.
  - STOP: on the mid-bit decision, update rx_data and the error flags, and pulse rx_valid for one clk.
  - Transition from STOP: if the stop majority is 1, go to IDLE (ready for a new start edge half a bit early). If the stop majority is 0, set rx_frame_err and go to BREAK.
  - BREAK: wait for synced rx = 1, then go to IDLE.
- Error flags hold until the next rx_valid. rx_data is still updated on error frames.
- TX and RX are fully independent; simultaneous activity has no interaction.
- Reset mid-frame: tx returns to 1 immediately. Any partial RX frame is discarded; no rx_valid.

Test Plan:
- Common bench settings: CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16, giving DIV=1 and 16 clk per bit.
- 8N1 loopback (tx tied to rx), send 0xA5:
  - tx pattern is 0,1,0,1,0,0,1,0,1,1, each bit held 16 clk.
  - tx_ready is low for 160 clk.
  - rx_valid pulses once with rx_data=0xA5 and both error flags 0.
- PARITY=2 (even), 8E1, send 0x07: parity bit on the line = 1, frame = 11 bits (176 clk), rx_parity_err=0. Then force the parity bit to 0 on rx: rx_parity_err=1, rx_data=0x07.
- Glitch: drive rx low for 4 clk, then high → no rx_valid, RX FSM back in IDLE within 9 clk.
- Framing error: 8N1 frame for 0x3C with the stop bit held 0 for 3 bit periods, then high:
  - rx_valid pulses with rx_frame_err=1 and rx_data=0x3C.
  - No second rx_valid occurs before the next valid start bit.
- DATA_BITS=5, STOP_BITS=2: send 0x1F followed immediately by 0x00 (tx_valid held high):
  - Each frame is 8 bits (128 clk); the gap between frames is at most 1 clk.
  - rx receives 0x1F then 0x00.
- Assert rst_n low mid-way through the DATA state of both TX and RX:
  - tx=1 and tx_ready=1 in the same cycle as reset assertion.
  - No rx_valid is produced.
  - The next full frame after release is received correctly.
